// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial ALU.
// Contents:
//   state_t   - controller states IDLE / BUSY / DONE
//   SEL_*     - operand B conditioning select encodings
//   SLICE_W   - width of one carry-lookahead slice
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_B    = 2'b00;
    localparam logic [1:0] SEL_NB   = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;
    localparam logic [1:0] SEL_ONES = 2'b11;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/nibble_serial_alu_if.sv
// Request/result bus of the nibble-serial ALU.
// Request side : in_valid, in_ready, a, b, s, cin
// Result side  : out_valid, out_ready, d, cout
//                (+ zero, negative, overflow when ALU_STATUS_FLAGS_EN is defined)
// Modports: slave = the ALU, master = the block driving requests / taking results.
interface nibble_serial_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       s;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             cout;
`ifdef ALU_STATUS_FLAGS_EN
    logic             zero;
    logic             negative;
    logic             overflow;
`endif

    modport slave (
        input  in_valid, a, b, s, cin, out_ready,
        output in_ready, out_valid, d, cout
`ifdef ALU_STATUS_FLAGS_EN
        , output zero, negative, overflow
`endif
    );

    modport master (
        output in_valid, a, b, s, cin, out_ready,
        input  in_ready, out_valid, d, cout
`ifdef ALU_STATUS_FLAGS_EN
        , input zero, negative, overflow
`endif
    );

endinterface

// File: rtl/cla_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   a4, b4 - slice operands
//   ci     - carry in
//   s4     - slice sum
//   co     - carry out of bit 3
//   c3     - carry into bit 3 (gives two's-complement overflow on the top slice)
module cla_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic               ci,
    output logic [SLICE_W-1:0] s4,
    output logic               co,
    output logic               c3
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a4 & b4;
    assign p = a4 ^ b4;

    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s4 = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_alu.sv
// Nibble-serial add/sub/inc/dec/pass unit: d = a + y + cin, y = b, ~b, 0 or all-ones.
// One 4-bit CLA slice per clock, carry registered between slices.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - request/result bus (slave modport)
// Optional: ALU_STATUS_FLAGS_EN adds zero/negative/overflow on the result side.
//
// state | meaning
// IDLE  | ready for a request; operands captured on in_valid
// BUSY  | one slice per cycle, idx selects the nibble
// DONE  | result valid, held until out_ready
module nibble_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_alu_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("nibble_serial_alu: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic               in_ready;
    logic               out_valid;
    logic               accept;
    logic               last;

    logic [WIDTH-1:0]   y_cond;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   d_nxt;
    logic               c_q;
    logic               cout_q;
    logic [IDX_W-1:0]   idx;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_co;
    logic               slice_c3;

    always_comb begin
        y_cond = '1;
        case (bus.s)
            SEL_B:    y_cond = bus.b;
            SEL_NB:   y_cond = ~bus.b;
            SEL_ZERO: y_cond = '0;
            default:  y_cond = '1;
        endcase
    end

    cla_slice u_slice (
        .a4 (a_q[idx*SLICE_W +: SLICE_W]),
        .b4 (y_q[idx*SLICE_W +: SLICE_W]),
        .ci (c_q),
        .s4 (slice_sum),
        .co (slice_co),
        .c3 (slice_c3)
    );

    // Result with the current nibble merged in; on the last slice this is the
    // complete sum, which the zero flag needs before it is registered.
    always_comb begin
        d_nxt = d_q;
        d_nxt[idx*SLICE_W +: SLICE_W] = slice_sum;
    end

    assign last   = (idx == LAST_IDX);
    assign accept = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            y_q    <= '0;
            d_q    <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_q <= bus.a;
            y_q <= y_cond;
            c_q <= bus.cin;
            idx <= '0;
        end else if (state == BUSY) begin
            d_q <= d_nxt;
            c_q <= slice_co;
            idx <= idx + 1'b1;
            if (last) cout_q <= slice_co;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.d         = d_q;
    assign bus.cout      = cout_q;

`ifdef ALU_STATUS_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == BUSY && last) begin
            zero_q <= (d_nxt == '0);
            neg_q  <= slice_sum[SLICE_W-1];
            ovf_q  <= slice_c3 ^ slice_co;
        end
    end

    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;
`else
    logic unused_c3;
    assign unused_c3 = slice_c3;
`endif

endmodule

// File: tb/tb_nibble_serial_alu.sv
module tb_nibble_serial_alu;

    localparam int W = 16;
    localparam int LAT = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   s;
        logic         cin;
        logic [W-1:0] d;
        logic         cout;
        logic         ovf;
        logic         neg;
        logic         zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    nibble_serial_alu_if #(.WIDTH(W)) bus ();

    nibble_serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cycles;
        @(negedge clk);
        bus.a = v.a; bus.b = v.b; bus.s = v.s; bus.cin = v.cin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // scramble inputs while busy: result must depend only on captured values
        bus.a = ~v.a; bus.b = ~v.b; bus.s = ~v.s; bus.cin = ~v.cin;
        wait_out_valid(cycles);
        check({tag, "_latency"}, 64'(cycles), 64'(LAT));
        check({tag, "_d"}, 64'(bus.d), 64'(v.d));
        check({tag, "_cout"}, 64'(bus.cout), 64'(v.cout));
`ifdef ALU_STATUS_FLAGS_EN
        check({tag, "_overflow"}, 64'(bus.overflow), 64'(v.ovf));
        check({tag, "_negative"}, 64'(bus.negative), 64'(v.neg));
        check({tag, "_zero"}, 64'(bus.zero), 64'(v.zero));
`endif
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int cycles;
        bit seen_valid;
        n_total = 0;
        n_pass  = 0;

        //             a        b        s      cin   d        cout ovf neg zero
        vecs[0]  = '{16'h00FF, 16'h0001, 2'b00, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0005, 16'h0007, 2'b01, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h0007, 16'h0005, 2'b01, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000, 16'h1234, 2'b11, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'h1234, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16'h1234, 16'h0000, 2'b11, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'hABCD, 16'h5555, 2'b10, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{16'h1000, 16'h0FFF, 2'b00, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h0010, 16'h0001, 2'b01, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h8000, 16'h8000, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{16'h8000, 16'h0001, 2'b01, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{16'h1234, 16'h1111, 2'b00, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.s = 2'b00; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_d", 64'(bus.d), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // backpressure: result held, new request waits for the out handshake
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.s = 2'b00; bus.cin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.a = 16'h0001; bus.b = 16'h0001;
        wait_out_valid(cycles);
        check("bp_latency", 64'(cycles), 64'(LAT));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_d_%0d", k), 64'(bus.d), 64'h3333);
            check($sformatf("bp_cout_%0d", k), 64'(bus.cout), 64'd0);
            check($sformatf("bp_in_ready_%0d", k), 64'(bus.in_ready), 64'd0);
            check($sformatf("bp_valid_%0d", k), 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 64'(bus.out_valid), 64'd0);
        check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_second_accepted", 64'(bus.in_ready), 64'd0);
        wait_out_valid(cycles);
        check("bp2_latency", 64'(cycles), 64'(LAT));
        check("bp2_d", 64'(bus.d), 64'h0002);
        @(posedge clk); #1;

        // abort in the 2nd BUSY cycle
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h1111; bus.s = 2'b00; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_d", 64'(bus.d), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("abort_no_valid", 64'(seen_valid), 64'd0);
        check("abort_in_ready_after", 64'(bus.in_ready), 64'd1);
        run_vec(vecs[13], "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
